// File: rtl/instr_issuer.sv
// Instruction issuer: buffers upstream instructions, issues them one at a time over the
// datapath start/finished handshake and queues the results of read instructions.
module instr_issuer #(
  parameter int INSTR_W     = 32,
  parameter int OPCODE_W    = 4,
  parameter int RESULT_W    = 12,
  parameter int READ_OPCODE = 2,
  parameter int IQ_DEPTH    = 4,
  parameter int RQ_DEPTH    = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instruction,
  output logic                dp_start,
  output logic [INSTR_W-1:0]  dp_instruction,
  input  logic                dp_finished,
  input  logic [RESULT_W-1:0] dp_result,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [RESULT_W-1:0] res_data,
  output logic                busy,
  output logic [15:0]         done_count
);

  localparam int IQ_AW = $clog2(IQ_DEPTH);
  localparam int RQ_AW = $clog2(RQ_DEPTH);
  localparam logic [IQ_AW:0]       IQ_FULL     = (IQ_AW+1)'(IQ_DEPTH);
  localparam logic [IQ_AW:0]       IQ_CNT_ONE  = (IQ_AW+1)'(1);
  localparam logic [IQ_AW:0]       IQ_CNT_ZERO = (IQ_AW+1)'(0);
  localparam logic [IQ_AW-1:0]     IQ_PTR_ONE  = IQ_AW'(1);
  localparam logic [IQ_AW-1:0]     IQ_PTR_ZERO = IQ_AW'(0);
  localparam logic [RQ_AW:0]       RQ_FULL     = (RQ_AW+1)'(RQ_DEPTH);
  localparam logic [RQ_AW:0]       RQ_CNT_ONE  = (RQ_AW+1)'(1);
  localparam logic [RQ_AW:0]       RQ_CNT_ZERO = (RQ_AW+1)'(0);
  localparam logic [RQ_AW-1:0]     RQ_PTR_ONE  = RQ_AW'(1);
  localparam logic [RQ_AW-1:0]     RQ_PTR_ZERO = RQ_AW'(0);
  localparam logic [OPCODE_W-1:0]  READ_OP     = OPCODE_W'(READ_OPCODE);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic                  dp_start_q, dp_start_d;
  logic [INSTR_W-1:0]    dp_instruction_q, dp_instruction_d;
  logic [15:0]           done_count_q, done_count_d;

  logic [INSTR_W-1:0]    iq_mem_q [IQ_DEPTH];
  logic [IQ_AW-1:0]      iq_wr_ptr_q, iq_wr_ptr_d, iq_rd_ptr_q, iq_rd_ptr_d;
  logic [IQ_AW:0]        iq_count_q, iq_count_d;
  logic [RESULT_W-1:0]   rq_mem_q [RQ_DEPTH];
  logic [RQ_AW-1:0]      rq_wr_ptr_q, rq_wr_ptr_d, rq_rd_ptr_q, rq_rd_ptr_d;
  logic [RQ_AW:0]        rq_count_q, rq_count_d;

  logic                  iq_push_s, iq_pop_s, rq_push_s, rq_pop_s;
  logic                  in_ready_s, res_valid_s, can_issue_s;
  logic                  head_is_read_s, issued_is_read_s;
  logic [INSTR_W-1:0]    iq_head_s;

  assign in_ready_s       = (iq_count_q < IQ_FULL);
  assign res_valid_s      = (rq_count_q != RQ_CNT_ZERO);
  assign iq_push_s        = in_valid && in_ready_s;
  assign rq_pop_s         = res_valid_s && res_ready;
  assign iq_head_s        = iq_mem_q[iq_rd_ptr_q];
  assign head_is_read_s   = (iq_head_s[INSTR_W-1 -: OPCODE_W] == READ_OP);
  assign issued_is_read_s = (dp_instruction_q[INSTR_W-1 -: OPCODE_W] == READ_OP);
  // A read may only issue when its result is guaranteed a slot on completion.
  assign can_issue_s      = (iq_count_q != IQ_CNT_ZERO) && dp_finished &&
                            (!head_is_read_s || (rq_count_q < RQ_FULL));

  // Issue sequencer: next state, start pulse, issued instruction and completion count.
  always_comb begin
    state_d          = state_q;
    dp_start_d       = 1'b0;
    dp_instruction_d = dp_instruction_q;
    done_count_d     = done_count_q;
    iq_pop_s         = 1'b0;
    rq_push_s        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (can_issue_s) begin
          iq_pop_s         = 1'b1;
          dp_instruction_d = iq_head_s;
          dp_start_d       = 1'b1;
          state_d          = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!dp_finished) begin
          state_d = S_WAIT_DONE;
        end else begin
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_DONE: begin
        if (dp_finished) begin
          rq_push_s    = issued_is_read_s;
          done_count_d = done_count_q + 16'd1;
          state_d      = S_IDLE;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    iq_wr_ptr_d = iq_push_s ? (iq_wr_ptr_q + IQ_PTR_ONE) : iq_wr_ptr_q;
    iq_rd_ptr_d = iq_pop_s  ? (iq_rd_ptr_q + IQ_PTR_ONE) : iq_rd_ptr_q;
    rq_wr_ptr_d = rq_push_s ? (rq_wr_ptr_q + RQ_PTR_ONE) : rq_wr_ptr_q;
    rq_rd_ptr_d = rq_pop_s  ? (rq_rd_ptr_q + RQ_PTR_ONE) : rq_rd_ptr_q;
    case ({iq_push_s, iq_pop_s})
      2'b10:   iq_count_d = iq_count_q + IQ_CNT_ONE;
      2'b01:   iq_count_d = iq_count_q - IQ_CNT_ONE;
      default: iq_count_d = iq_count_q;
    endcase
    case ({rq_push_s, rq_pop_s})
      2'b10:   rq_count_d = rq_count_q + RQ_CNT_ONE;
      2'b01:   rq_count_d = rq_count_q - RQ_CNT_ONE;
      default: rq_count_d = rq_count_q;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q          <= S_IDLE;
      dp_start_q       <= 1'b0;
      dp_instruction_q <= {INSTR_W{1'b0}};
      done_count_q     <= 16'd0;
      iq_wr_ptr_q      <= IQ_PTR_ZERO;
      iq_rd_ptr_q      <= IQ_PTR_ZERO;
      iq_count_q       <= IQ_CNT_ZERO;
      rq_wr_ptr_q      <= RQ_PTR_ZERO;
      rq_rd_ptr_q      <= RQ_PTR_ZERO;
      rq_count_q       <= RQ_CNT_ZERO;
    end else begin
      state_q          <= state_d;
      dp_start_q       <= dp_start_d;
      dp_instruction_q <= dp_instruction_d;
      done_count_q     <= done_count_d;
      iq_wr_ptr_q      <= iq_wr_ptr_d;
      iq_rd_ptr_q      <= iq_rd_ptr_d;
      iq_count_q       <= iq_count_d;
      rq_wr_ptr_q      <= rq_wr_ptr_d;
      rq_rd_ptr_q      <= rq_rd_ptr_d;
      rq_count_q       <= rq_count_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (iq_push_s) begin
      iq_mem_q[iq_wr_ptr_q] <= in_instruction;
    end
    if (rq_push_s) begin
      rq_mem_q[rq_wr_ptr_q] <= dp_result;
    end
  end

  assign in_ready       = in_ready_s;
  assign res_valid      = res_valid_s;
  assign res_data       = rq_mem_q[rq_rd_ptr_q];
  assign dp_start       = dp_start_q;
  assign dp_instruction = dp_instruction_q;
  assign done_count     = done_count_q;
  assign busy           = (state_q != S_IDLE) || (iq_count_q != IQ_CNT_ZERO);

endmodule

// File: tb/tb_instr_issuer.sv
// Bench for instr_issuer: queue-based reference model checked every cycle, a simple
// datapath responder, and directed scenarios with hand-computed expectations.
module tb_instr_issuer;

  logic        clock = 1'b0;
  logic        resetn, in_valid, in_ready, dp_start, dp_finished, res_valid, res_ready, busy;
  logic [31:0] in_instruction, dp_instruction;
  logic [11:0] dp_result, res_data;
  logic [15:0] done_count;
  logic        dp_fin_r, dp_hold;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_pulses = 0;
  bit          chk_en   = 1'b0;
  int          dp_lat   = 1;
  logic [11:0] dp_ofs   = 12'h000;

  // reference model state
  logic [31:0] iq_m[$];
  logic [11:0] rq_m[$];
  bit          m_out = 1'b0, m_start = 1'b0, m_acked = 1'b0;
  bit          m_go, m_pop_r, m_push_i;
  logic [31:0] m_dp_instr = 32'h0;
  logic [15:0] m_done = 16'h0;

  assign dp_finished = dp_fin_r & ~dp_hold;

  instr_issuer dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_instruction(in_instruction),
    .dp_start(dp_start), .dp_instruction(dp_instruction),
    .dp_finished(dp_finished), .dp_result(dp_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done_count(done_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Datapath responder: drops finished after seeing start, raises it with a result later.
  initial begin
    logic [11:0] cap;
    forever begin
      @(negedge clock);
      if (dp_start === 1'b1) begin
        cap = dp_instruction[11:0] + dp_ofs;
        @(posedge clock);
        #1 dp_fin_r = 1'b0;
        repeat (dp_lat) @(posedge clock);
        #1;
        dp_result = cap;
        dp_fin_r  = 1'b1;
      end
    end
  end

  // Reference model: queues plus an outstanding-instruction record, updated per edge.
  always @(posedge clock) begin
    if (!resetn) begin
      iq_m.delete();
      rq_m.delete();
      m_out = 1'b0; m_start = 1'b0; m_acked = 1'b0;
      m_dp_instr = 32'h0;
      m_done = 16'h0;
    end else begin
      m_pop_r  = (rq_m.size() > 0) && res_ready;
      m_push_i = in_valid && (iq_m.size() < 4);
      m_go     = !m_out && (iq_m.size() > 0) && dp_finished &&
                 ((iq_m[0][31:28] != 4'd2) || (rq_m.size() < 4));
      if (m_pop_r) void'(rq_m.pop_front());
      if (m_go) begin
        m_dp_instr = iq_m.pop_front();
        m_out = 1'b1; m_start = 1'b1; m_acked = 1'b0;
      end else if (m_out) begin
        if (m_start) m_start = 1'b0;
        else if (!m_acked) begin
          if (!dp_finished) m_acked = 1'b1;
        end else if (dp_finished) begin
          if (m_dp_instr[31:28] == 4'd2) rq_m.push_back(dp_result);
          m_done = m_done + 16'd1;
          m_out  = 1'b0;
        end
      end
      if (m_push_i) iq_m.push_back(in_instruction);
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (dp_start === 1'b1) n_pulses++;
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(iq_m.size() < 4));
      check("res_valid", 32'(res_valid), 32'(rq_m.size() > 0));
      if (rq_m.size() > 0) check("res_data", 32'(res_data), 32'(rq_m[0]));
      check("dp_start", 32'(dp_start), 32'(m_start));
      check("dp_instruction", dp_instruction, m_dp_instr);
      check("busy", 32'(busy), 32'(m_out || (iq_m.size() > 0)));
      check("done_count", 32'(done_count), 32'(m_done));
    end
  end

  task automatic push_instr(input logic [31:0] instr);
    bit ok = 1'b0;
    int guard = 0;
    in_valid = 1'b1;
    in_instruction = instr;
    while (!ok && guard < 200) begin
      ok = in_ready;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check("push_accepted", 32'(ok), 32'h1);
  endtask

  task automatic wait_idle(input int budget);
    int g = 0;
    while (busy && g < budget) begin
      tick();
      g++;
    end
    check("idle_reached", 32'(busy), 32'h0);
  endtask

  task automatic pop_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int g;
    resetn = 1'b0; in_valid = 1'b0; in_instruction = 32'h0; res_ready = 1'b0;
    dp_hold = 1'b0; dp_fin_r = 1'b1; dp_result = 12'h000;
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_dp_start", 32'(dp_start), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done_count", 32'(done_count), 32'h0);
    resetn = 1'b1;
    tick();

    // unknown opcode 0: one start pulse, no result
    p0 = n_pulses;
    dp_lat = 1;
    push_instr(32'h0000_1234);
    wait_idle(50);
    check("s2_pulses", 32'(n_pulses - p0), 32'h1);
    check("s2_dp_instr", dp_instruction, 32'h0000_1234);
    check("s2_done", 32'(done_count), 32'h1);
    check("s2_no_result", 32'(res_valid), 32'h0);

    // read at 0x0010 returning 0xABC after a 3-cycle busy window
    dp_ofs = 12'hAAC;
    dp_lat = 3;
    push_instr(32'h2000_0010);
    wait_idle(50);
    check("s3_res_valid", 32'(res_valid), 32'h1);
    check("s3_res_data", 32'(res_data), 32'h0ABC);
    check("s3_done", 32'(done_count), 32'h2);
    pop_result();
    check("s3_popped", 32'(res_valid), 32'h0);
    dp_ofs = 12'h000;
    dp_lat = 1;

    // fill the instruction FIFO while the datapath is held busy
    dp_hold = 1'b1;
    for (int i = 1; i <= 4; i++) push_instr(32'h1000_0000 + 32'(i));
    check("s4_full", 32'(in_ready), 32'h0);
    check("s4_busy", 32'(busy), 32'h1);
    check("s4_no_start", 32'(dp_start), 32'h0);
    p0 = n_pulses;
    dp_hold = 1'b0;
    push_instr(32'h3000_0005);
    wait_idle(100);
    check("s4_pulses", 32'(n_pulses - p0), 32'h5);
    check("s4_done", 32'(done_count), 32'h7);
    check("s4_last_instr", dp_instruction, 32'h3000_0005);

    // result FIFO full blocks a read, and the plot behind it waits too
    for (int i = 1; i <= 4; i++) push_instr(32'h2000_0100 + 32'(i));
    wait_idle(100);
    check("s5_head", 32'(res_data), 32'h0101);
    check("s5_done4", 32'(done_count), 32'hB);
    p0 = n_pulses;
    push_instr(32'h2000_0105);
    push_instr(32'h1000_0200);
    repeat (8) tick();
    check("s5_stalled", 32'(n_pulses - p0), 32'h0);
    check("s5_busy", 32'(busy), 32'h1);
    check("s5_held_instr", dp_instruction, 32'h2000_0104);
    pop_result();
    wait_idle(100);
    check("s5_pulses", 32'(n_pulses - p0), 32'h2);
    check("s5_last_instr", dp_instruction, 32'h1000_0200);
    check("s5_done", 32'(done_count), 32'hD);
    for (int i = 2; i <= 5; i++) begin
      check("s5_drain", 32'(res_data), 32'h0100 + 32'(i));
      pop_result();
    end
    check("s5_empty", 32'(res_valid), 32'h0);

    // reset while a read is in its done-wait
    dp_lat = 6;
    push_instr(32'h2000_0300);
    g = 0;
    while (dp_start !== 1'b1 && g < 20) begin
      tick();
      g++;
    end
    check("s6_started", 32'(dp_start), 32'h1);
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    check("s6_res_valid", 32'(res_valid), 32'h0);
    check("s6_in_ready", 32'(in_ready), 32'h1);
    check("s6_dp_start", 32'(dp_start), 32'h0);
    check("s6_done", 32'(done_count), 32'h0);
    check("s6_busy", 32'(busy), 32'h0);
    check("s6_dp_instr", dp_instruction, 32'h0);
    resetn = 1'b1;
    repeat (10) tick();
    dp_lat = 1;
    push_instr(32'h1000_0400);
    wait_idle(50);
    check("s6_recover_done", 32'(done_count), 32'h1);
    check("s6_recover_res", 32'(res_valid), 32'h0);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
